lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
// - Load/store unit directly downstream of the hart execute stage. It replaces the combinational dmem port.
// - Accepts one byte/half/word access per request (addr = ALU result, wdata = rs2).
// - Aligns it to a word address with byte mask, drives a ready/valid memory port of variable latency,
//   and returns the extended load data (or a store ack) plus a trap flag to writeback.
// PARAMETERS
// - TIMEOUT   default 255  cycles in REQ+WAIT before abort with trap; 0 = never time out
// PORTS
// - i_clk            in   1   global clock
// - i_rst            in   1   synchronous active-high reset
// - i_req_valid      in   1   core access request
// - o_req_ready      out  1   LSU can accept (high only in IDLE)
// - i_req_wen        in   1   1 = store, 0 = load
// - i_req_addr       in   32  byte address
// - i_req_size       in   2   00 byte, 01 half, 10 word, 11 illegal
// - i_req_unsigned   in   1   zero-extend load (lbu/lhu)
// - i_req_wdata      in   32  store data, value in low bits
// - o_rsp_valid      out  1   one-cycle completion pulse
// - o_rsp_rdata      out  32  extended load data; 0 for stores/traps
// - o_rsp_trap       out  1   misaligned, illegal size or timeout
// - o_mem_valid      out  1   memory request valid
// - i_mem_ready      in   1   memory accepts request
// - o_mem_addr       out  32  word-aligned address ({addr[31:2],2'b00})
// - o_mem_ren        out  1   read request (never with o_mem_wen)
// - o_mem_wen        out  1   write request
// - o_mem_wdata      out  32  wdata << (8*addr[1:0])
// - o_mem_mask       out  4   byte 4'b0001<<off, half 4'b0011<<off, word 4'b1111
// - i_mem_rsp_valid  in   1   read data / write ack valid
// - i_mem_rdata      in   32  read word
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0 except o_req_ready=1; timeout counter 0.
// - FSM IDLE -> REQ -> WAIT -> IDLE. Request fields are latched on accept (i_req_valid & o_req_ready).
// - Accept-time checks:
//   - size 11, half with addr[0]=1, or word with addr[1:0]!=0 -> next cycle o_rsp_valid=1, o_rsp_trap=1,
//     rdata=0; no memory request; state stays IDLE.
// - REQ:
//   - o_mem_valid=1; addr/ren/wen/wdata/mask held stable until i_mem_ready.
//   - Handshake -> WAIT.
// - WAIT:
//   - o_mem_valid=0; on i_mem_rsp_valid -> complete, -> IDLE.
//   - A response arriving in the handshake cycle itself is not sampled.
// - Load completion data: rdata >> (8*off), then sign/zero-extend from bit 7 (byte) or bit 15 (half).
//   Store: rdata=0, trap=0.
// - Timeout:
//   - The counter increments each cycle in REQ/WAIT and clears on return to IDLE.
//   - At count==TIMEOUT (TIMEOUT>0): complete with trap=1, -> IDLE, o_mem_valid drops.
// - i_mem_rsp_valid while in IDLE or REQ is ignored (stale response after timeout).
// - Back-to-back: o_req_ready=1 again in the cycle after completion. Minimum load/store = 3 cycles
//   (accept, REQ w/ ready, WAIT w/ rsp).
// - Reset mid-operation: abandon transaction; no o_rsp_valid; o_mem_valid low the next cycle.
// - o_rsp_valid is a single-cycle pulse; the core must not re-request until it sees it.
// CONFIGURATION
// - LSU_RSP_REG_EN defined:
//   - rsp_valid/rdata/trap come from flops, one cycle after i_mem_rsp_valid (or the trap decision).
//   - Ready returns with the rsp pulse.
// - Undefined:
//   - Memory responses: rsp_* driven combinationally in the same cycle as i_mem_rsp_valid.
//   - Accept-time and timeout traps: always registered, next cycle, in both configurations.
// TESTING
// - lb addr 0x1003, mem word 0x80AA_BBCC -> mask 4'b1000, mem_addr 0x1000, rdata 0xFFFF_FF80; lbu -> 0x0000_0080
// - sh addr 0x2002 wdata 0x0000_1234 -> mask 4'b1100, o_mem_wdata 0x1234_0000, ack -> rsp trap=0
// - lw addr 0x3001 -> rsp trap=1 next cycle, o_mem_valid never asserts; size 2'b11 same result
// - i_mem_ready low 5 cycles -> o_mem_* stable throughout; rsp 2 cycles after ready -> correct data
// - TIMEOUT=4, no rsp -> trap after 4 cycles in REQ/WAIT; late rsp ignored; next request serviced normally
// - i_rst asserted in WAIT -> IDLE next cycle, o_req_ready=1, no rsp pulse; repeat with LSU_RSP_REG_EN (+1 latency)

Source files
------------

// File: rtl/lsu.sv
// ============================================================================
// Module   : lsu
// Purpose  : Load/store unit between execute and writeback. It aligns byte,
//            half and word accesses onto a ready/valid word-wide memory port
//            and returns extended load data, a store ack, or a trap.
// Options  : `define LSU_RSP_REG_EN registers memory responses (one extra cycle).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_wen,
    input  logic [31:0] i_req_addr,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_trap,
    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_rsp_valid,
    input  logic [31:0] i_mem_rdata
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] c_TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic           r_wen;
    logic           r_uns;
    logic [1:0]     r_size;
    logic [1:0]     r_off;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic [3:0]     r_mask;
    logic [CW-1:0]  r_cnt;

    logic           r_rsp_valid;
    logic           r_rsp_trap;
    logic [31:0]    r_rsp_rdata;

    logic           w_accept;
    logic           w_bad;
    logic [3:0]     w_mask_in;
    logic           w_mem_done;
    logic           w_timeout;
    logic           w_to_fire;
    logic [31:0]    w_shift;
    logic [31:0]    w_ld_data;

    assign o_req_ready = (r_state == S_IDLE);
    assign w_accept    = i_req_valid & o_req_ready;
    assign w_mem_done  = (r_state == S_WAIT) & i_mem_rsp_valid;
    assign w_timeout   = (TIMEOUT != 0) && (r_state != S_IDLE) && (r_cnt == c_TO_LAST);
    // A real response in the final WAIT cycle beats the timeout.
    assign w_to_fire   = w_timeout & ~w_mem_done;

    // Alignment check and byte-lane mask for the incoming request
    always_comb begin
        w_bad     = 1'b0;
        w_mask_in = 4'b1111;
        case (i_req_size)
            2'b00: begin
                w_bad     = 1'b0;
                w_mask_in = 4'b0001 << i_req_addr[1:0];
            end
            2'b01: begin
                w_bad     = i_req_addr[0];
                w_mask_in = 4'b0011 << i_req_addr[1:0];
            end
            2'b10: begin
                w_bad     = |i_req_addr[1:0];
                w_mask_in = 4'b1111;
            end
            default: begin
                w_bad     = 1'b1;
                w_mask_in = 4'b1111;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_bad) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end else if (i_mem_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_mem_rsp_valid || w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wen   <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'b00;
            r_off   <= 2'b00;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_mask  <= 4'd0;
        end else if (w_accept) begin
            r_wen   <= i_req_wen;
            r_uns   <= i_req_unsigned;
            r_size  <= i_req_size;
            r_off   <= i_req_addr[1:0];
            r_addr  <= {i_req_addr[31:2], 2'b00};
            r_wdata <= i_req_wdata << {i_req_addr[1:0], 3'b000};
            r_mask  <= w_mask_in;
        end
    end

    // Cycles spent in REQ/WAIT; cleared whenever the FSM heads back to IDLE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if ((r_state != S_IDLE) && (w_state_nxt != S_IDLE)) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_mem_valid = (r_state == S_REQ);
    assign o_mem_ren   = (r_state == S_REQ) & ~r_wen;
    assign o_mem_wen   = (r_state == S_REQ) &  r_wen;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_mem_mask  = r_mask;

    // Bring the addressed lane down to bit 0, then extend by access size
    always_comb begin
        w_shift   = i_mem_rdata >> {r_off, 3'b000};
        w_ld_data = w_shift;
        case (r_size)
            2'b00:   w_ld_data = {{24{~r_uns & w_shift[7]}},  w_shift[7:0]};
            2'b01:   w_ld_data = {{16{~r_uns & w_shift[15]}}, w_shift[15:0]};
            default: w_ld_data = w_shift;
        endcase
        if (r_wen) begin
            w_ld_data = 32'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_trap  <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_trap  <= 1'b0;
            r_rsp_rdata <= 32'd0;
            if ((w_accept && w_bad) || w_to_fire) begin
                r_rsp_valid <= 1'b1;
                r_rsp_trap  <= 1'b1;
            end
`ifdef LSU_RSP_REG_EN
            if (w_mem_done) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= w_ld_data;
            end
`endif
        end
    end

`ifdef LSU_RSP_REG_EN
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_trap  = r_rsp_trap;
    assign o_rsp_rdata = r_rsp_rdata;
`else
    assign o_rsp_valid = r_rsp_valid | w_mem_done;
    assign o_rsp_trap  = r_rsp_trap;
    assign o_rsp_rdata = w_mem_done ? w_ld_data : r_rsp_rdata;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
// Module   : tb_lsu
// Purpose  : Self-checking bench for lsu: directed cases plus randomized
//            accesses compared against a byte-level reference model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lsu;

    localparam int TO = 10;
`ifdef LSU_RSP_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_uns;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_trap;
    logic [31:0] rsp_rdata;
    logic        mem_valid, mem_ready, mem_ren, mem_wen, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_mask;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wen(req_wen),
        .i_req_addr(req_addr), .i_req_size(req_size), .i_req_unsigned(req_uns),
        .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_trap(rsp_trap),
        .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
        .o_mem_ren(mem_ren), .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata),
        .o_mem_mask(mem_mask), .i_mem_rsp_valid(mem_rsp_valid), .i_mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_bad(input logic [31:0] a, input logic [1:0] s);
        return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                             input logic [1:0] s, input bit uns);
        logic [7:0]  b [4];
        logic [31:0] r = 32'd0;
        int off = int'(a[1:0]);
        int n = nbytes(s);
        for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
        for (int i = 0; i < n; i++) r[8*i +: 8] = b[off + i];
        if (!uns && n < 4 && r[8*n - 1])
            for (int i = n; i < 4; i++) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic logic [3:0] ref_mask(input logic [31:0] a, input logic [1:0] s);
        logic [3:0] m = 4'd0;
        for (int i = 0; i < nbytes(s); i++) m[int'(a[1:0]) + i] = 1'b1;
        return m;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; req_wen = 1'b0; req_uns = 1'b0; req_size = 2'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        mem_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'd0;
    endtask

    // One full access: accept cycle, REQ/WAIT cycles, completion cycle.
    // rdy_d = cycles with i_mem_ready low before the handshake,
    // rsp_d = cycles from handshake to i_mem_rsp_valid (>=1).
    task automatic access(input bit wen, input logic [31:0] addr, input logic [1:0] size,
                          input bit uns, input logic [31:0] wdata, input logic [31:0] word,
                          input int rdy_d, input int rsp_d);
        bit          bad    = is_bad(addr, size);
        int          c      = rdy_d + rsp_d;
        bit          normal = (c < TO);
        int          e      = normal ? c : TO - 1;
        logic [31:0] exp_rd = wen ? 32'd0 : ref_load(word, addr, size, uns);
        bit          in_req;
        bit          exp_v;

        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
        req_uns = uns; req_wdata = wdata;
        mem_ready = 1'b0; mem_rsp_valid = 1'($urandom); mem_rdata = $urandom;
        @(negedge clk);
        chk("accept_ready", req_ready, 1);
        chk("accept_mem_valid", mem_valid, 0);
        chk("accept_rsp_valid", rsp_valid, 0);
        tick();
        req_valid = 1'b0; req_wen = 1'($urandom); req_addr = $urandom;
        req_size = 2'($urandom); req_uns = 1'($urandom); req_wdata = $urandom;
        mem_rsp_valid = 1'b0;

        if (bad) begin
            @(negedge clk);
            chk("badreq_rsp_valid", rsp_valid, 1);
            chk("badreq_trap", rsp_trap, 1);
            chk("badreq_rdata", rsp_rdata, 0);
            chk("badreq_mem_valid", mem_valid, 0);
            chk("badreq_ready", req_ready, 1);
            tick();
            idle_inputs();
            return;
        end

        for (int k = 0; k <= e; k++) begin
            in_req    = (k <= rdy_d);
            mem_ready = in_req && (k == rdy_d);
            if (in_req) begin
                mem_rsp_valid = 1'($urandom);
                mem_rdata     = $urandom;
            end else begin
                mem_rsp_valid = (k == c);
                mem_rdata     = (k == c) ? word : $urandom;
            end
            @(negedge clk);
            chk("busy_ready", req_ready, 0);
            chk("mem_valid", mem_valid, 32'(in_req));
            if (in_req) begin
                chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
                chk("mem_mask", mem_mask, ref_mask(addr, size));
                chk("mem_wdata", mem_wdata, wdata << (8 * addr[1:0]));
                chk("mem_ren", mem_ren, 32'(!wen));
                chk("mem_wen", mem_wen, 32'(wen));
            end
            exp_v = normal && (k == c) && (LAT == 0);
            chk("busy_rsp_valid", rsp_valid, 32'(exp_v));
            if (exp_v) begin
                chk("comb_rsp_trap", rsp_trap, 0);
                chk("comb_rsp_rdata", rsp_rdata, exp_rd);
            end
            tick();
        end

        // Completion cycle: any response here is late and must be ignored
        mem_ready = 1'b0; mem_rsp_valid = 1'($urandom); mem_rdata = $urandom;
        @(negedge clk);
        chk("done_ready", req_ready, 1);
        chk("done_mem_valid", mem_valid, 0);
        exp_v = !normal || (LAT == 1);
        chk("done_rsp_valid", rsp_valid, 32'(exp_v));
        if (exp_v) begin
            chk("done_rsp_trap", rsp_trap, 32'(!normal));
            chk("done_rsp_rdata", rsp_rdata, normal ? exp_rd : 32'd0);
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] ad;
        int          rd;

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_trap", rsp_trap, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_ren", mem_ren, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_mask", mem_mask, 0);
        tick();

        // Spot-check the model itself against literal values
        chk("model_lb", ref_load(32'h80AA_BBCC, 32'h1003, 2'd0, 1'b0), 32'hFFFF_FF80);
        chk("model_lbu", ref_load(32'h80AA_BBCC, 32'h1003, 2'd0, 1'b1), 32'h0000_0080);
        chk("model_sh_mask", 32'(ref_mask(32'h2002, 2'd1)), 32'hC);

        access(1'b0, 32'h1003, 2'd0, 1'b0, 32'h0, 32'h80AA_BBCC, 0, 1);   // lb
        access(1'b0, 32'h1003, 2'd0, 1'b1, 32'h0, 32'h80AA_BBCC, 0, 1);   // lbu
        access(1'b1, 32'h2002, 2'd1, 1'b0, 32'h0000_1234, 32'h0, 1, 1);   // sh
        access(1'b0, 32'h3001, 2'd2, 1'b0, 32'h0, 32'h0, 0, 1);           // lw misaligned
        access(1'b0, 32'h3000, 2'd3, 1'b0, 32'h0, 32'h0, 0, 1);           // illegal size
        access(1'b0, 32'h3003, 2'd1, 1'b0, 32'h0, 32'h0, 0, 1);           // lh misaligned
        access(1'b0, 32'h4002, 2'd1, 1'b0, 32'h0, 32'h8001_7FFF, 5, 2);   // ready stalls
        access(1'b0, 32'h5000, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 40);  // timeout in WAIT
        access(1'b0, 32'h5004, 2'd2, 1'b0, 32'h0, 32'h1357_9BDF, 0, 1);   // serviced after
        access(1'b1, 32'h6000, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h0, 30, 1);  // timeout in REQ
        access(1'b0, 32'h6001, 2'd0, 1'b0, 32'h0, 32'h0000_7F00, 2, TO - 3); // last legal cycle

        // Reset while in WAIT: transaction abandoned, no response pulse
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h7000; req_size = 2'd2;
        tick();
        req_valid = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rstwait_mem_valid", mem_valid, 0);
        chk("rstwait_rsp_valid", rsp_valid, 0);
        tick();
        rst = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("rstwait_ready", req_ready, 1);
        chk("rstwait_mem_valid2", mem_valid, 0);
        chk("rstwait_rsp_valid2", rsp_valid, 0);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("rstwait_rsp_valid3", rsp_valid, 0);
        tick();

        for (int n = 0; n < 80; n++) begin
            sz = 2'($urandom);
            ad = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd3) sz = 2'd2;
                if (sz == 2'd1) ad[0] = 1'b0;
                if (sz == 2'd2) ad[1:0] = 2'b00;
            end
            rd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(6, 12))
                                               : int'($urandom_range(1, 4));
            access(1'($urandom), ad, sz, 1'($urandom), $urandom, $urandom,
                   int'($urandom_range(0, 4)), rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
